// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan encoder.
package keypad_pkg;

    localparam int unsigned KP_ROWS   = 4;
    localparam int unsigned KP_COLS   = 4;
    localparam logic [3:0]  COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        StIdle,
        StDeb,
        StPressed,
        StRel
    } kp_state_e;

    typedef enum logic [1:0] {
        FrNone,
        FrOne,
        FrMulti
    } frame_class_e;

    // Frame bit index is col*4+row; the key code is {row, col}.
    function automatic logic [3:0] onehot16_to_code(input logic [15:0] onehot);
        logic [3:0] code;
        logic [3:0] idx;
        code = '0;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            if (onehot[i]) begin
                code = {idx[1:0], idx[3:2]};
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/kp_scan_tick.sv
// Column-step divider and 2-bit column counter for the keypad scanner.
module kp_scan_tick #(
    parameter int unsigned SCAN_DIV = 100
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       tick_o,
    output logic [1:0] col_o,
    output logic       frame_end_o
);

    localparam int unsigned     DivW    = $clog2(SCAN_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      col_q, col_d;

    assign tick_o      = (div_q == DivLast);
    assign frame_end_o = tick_o && (col_q == 2'd3);
    assign col_o       = col_q;

    always_comb begin
        div_d = tick_o ? '0 : div_q + 1'b1;
        col_d = tick_o ? col_q + 2'd1 : col_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            col_q <= '0;
        end else begin
            div_q <= div_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner: active-low column strobe, frame debounce, one encoded key per press.
// Build option: define TYPEMATIC_EN to auto-repeat key_valid while a single key stays held.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100,
    parameter int unsigned DEB_FRAMES = 8,
    parameter int unsigned REP_DELAY  = 50,
    parameter int unsigned REP_PERIOD = 10
) (
    input  logic       clk100khz,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned     CntW      = $clog2(DEB_FRAMES + 1);
    localparam logic [CntW-1:0] CntMax    = {CntW{1'b1}};
    localparam logic [CntW-1:0] DebTarget = CntW'(DEB_FRAMES);

    if (SCAN_DIV < 4 || DEB_FRAMES == 0 || REP_DELAY == 0 || REP_PERIOD == 0) begin : g_param_check
        $error("keypad_scan_encoder: illegal parameter value");
    end

    logic [3:0]      row_s1_q, row_s2_q;
    logic            tick, frame_end;
    logic [1:0]      col;
    logic [15:0]     frame_q, frame_d;
    frame_class_e    fclass;
    logic [3:0]      fcode;
    kp_state_e       state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;

    kp_scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_tick (
        .clk_i      (clk100khz),
        .rst_i      (rst),
        .tick_o     (tick),
        .col_o      (col),
        .frame_end_o(frame_end)
    );

    assign col_out   = ~(4'b0001 << col);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    // The column sampled on a frame-end tick is folded in before classifying.
    always_comb begin
        frame_d = frame_q;
        if (tick) begin
            frame_d[{col, 2'b00} +: KP_ROWS] = ~row_s2_q;
        end
    end

    always_comb begin
        if (frame_d == '0) begin
            fclass = FrNone;
        end else if ((frame_d & (frame_d - 16'd1)) == '0) begin
            fclass = FrOne;
        end else begin
            fclass = FrMulti;
        end
    end

    assign fcode   = onehot16_to_code(frame_d);
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

`ifdef TYPEMATIC_EN
    localparam int unsigned RepMax = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    logic [RepW-1:0] rep_q, rep_d, rep_inc;
    logic            rep_done_q, rep_done_d;

    assign rep_inc = rep_q + 1'b1;

    always_ff @(posedge clk100khz) begin
        if (rst) begin
            rep_q      <= '0;
            rep_done_q <= 1'b0;
        end else begin
            rep_q      <= rep_d;
            rep_done_q <= rep_done_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef TYPEMATIC_EN
        rep_d       = rep_q;
        rep_done_d  = rep_done_q;
`endif
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (fclass == FrOne) begin
                        state_d = StDeb;
                        cand_d  = fcode;
                        cnt_d   = CntW'(1);
                    end
                end
                StDeb: begin
                    if (fclass == FrOne && fcode == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DebTarget) begin
                            state_d     = StPressed;
                            cnt_d       = '0;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
`ifdef TYPEMATIC_EN
                            rep_d       = '0;
                            rep_done_d  = 1'b0;
`endif
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StPressed: begin
                    if (fclass == FrNone) begin
                        state_d = StRel;
                        cnt_d   = CntW'(1);
                    end
`ifdef TYPEMATIC_EN
                    // First repeat after REP_DELAY frames, later ones every REP_PERIOD.
                    if (fclass == FrOne && fcode == key_code_q) begin
                        if (rep_inc >= (rep_done_q ? RepW'(REP_PERIOD) : RepW'(REP_DELAY))) begin
                            key_valid_d = 1'b1;
                            rep_d       = '0;
                            rep_done_d  = 1'b1;
                        end else begin
                            rep_d = rep_inc;
                        end
                    end else begin
                        rep_d      = '0;
                        rep_done_d = 1'b0;
                    end
`endif
                end
                StRel: begin
                    if (fclass == FrNone) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DebTarget) begin
                            state_d    = StIdle;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end
                    end else begin
                        state_d = StPressed;
                        cnt_d   = '0;
`ifdef TYPEMATIC_EN
                        rep_d      = '0;
                        rep_done_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk100khz) begin
        if (rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            frame_q     <= '0;
            state_q     <= StIdle;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_s1_q    <= row_in;
            row_s2_q    <= row_s1_q;
            frame_q     <= frame_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Scoreboard bench for keypad_scan_encoder with a frame-level keypad model.
module tb_keypad_scan_encoder;

    localparam int unsigned SCAN_DIV   = 4;
    localparam int unsigned DEB_FRAMES = 3;
    localparam int unsigned REP_DELAY  = 4;
    localparam int unsigned REP_PERIOD = 2;
    localparam int unsigned FRAME_CYC  = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = '0;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  exp_q[$];

    // Model state: pressed/released status at the granularity of whole frames.
    bit          m_held = 1'b0;
    int          m_run = 0;
    logic [3:0]  m_key = '0;
    int          m_clear = 0;
    int          m_hold = 0;
    logic [3:0]  m_code = '0;

    always #5 clk = ~clk;

    keypad_scan_encoder #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_FRAMES(DEB_FRAMES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) dut (
        .clk100khz(clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Matrix: a pressed key at (r,c) pulls row r low while column c is strobed.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_out[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c*4 + r]) row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] key_of(input logic [15:0] s);
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (s[i]) k = (i % 4) * 4 + i / 4;
        end
        return 4'(k);
    endfunction

    task automatic model_reset();
        m_held  = 1'b0;
        m_run   = 0;
        m_clear = 0;
        m_hold  = 0;
        m_code  = '0;
    endtask

    task automatic model_frame(input logic [15:0] s);
        int         n;
        logic [3:0] k;
        n = $countones(s);
        k = key_of(s);
        if (!m_held) begin
            if (n == 1 && (m_run == 0 || k == m_key)) begin
                m_run++;
                m_key = k;
            end else begin
                m_run = 0;
            end
            if (m_run == DEB_FRAMES) begin
                m_held  = 1'b1;
                m_code  = k;
                m_run   = 0;
                m_clear = 0;
                m_hold  = 0;
                exp_q.push_back(k);
            end
        end else if (n == 0) begin
            m_clear++;
            m_hold = 0;
            if (m_clear == DEB_FRAMES) begin
                m_held  = 1'b0;
                m_clear = 0;
            end
        end else begin
            if (m_clear == 0 && n == 1 && k == m_code) begin
                m_hold++;
`ifdef TYPEMATIC_EN
                if (m_hold >= REP_DELAY && (m_hold - REP_DELAY) % REP_PERIOD == 0)
                    exp_q.push_back(m_code);
`endif
            end else begin
                m_hold = 0;
            end
            m_clear = 0;
        end
    endtask

    // Called at a frame boundary (#1 after the frame-end edge); returns at the next one.
    task automatic run_frame(input logic [15:0] s);
        pressed = s;
        @(posedge clk);
        #1;
        chk("pulse_pending", exp_q.size(), 0);
        model_frame(s);
        repeat (FRAME_CYC - 1) @(posedge clk);
        #1;
        chk("key_held", key_held, m_held);
        chk("key_code", key_code, m_code);
    endtask

    task automatic run_frames(input logic [15:0] s, input int n);
        for (int i = 0; i < n; i++) run_frame(s);
    endtask

    task automatic mid_reset(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_col_out", col_out, 4'b1110);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_held", key_held, 0);
        chk("rst_key_code", key_code, 0);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every key_valid pulse must match the next expected code.
    logic       prev_valid = 1'b0;
    logic [3:0] exp_code;
    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (prev_valid) begin
                failures++;
                $display("FAIL valid_double: key_valid high two cycles in a row at %0t", $time);
            end
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: code %0h, expected no pulse at %0t",
                         key_code, $time);
            end else begin
                exp_code = exp_q.pop_front();
                if (key_code !== exp_code || key_held !== 1'b1) begin
                    failures++;
                    $display("FAIL pulse_code: code %0h held %0b, expected code %0h held 1 at %0t",
                             key_code, key_held, exp_code, $time);
                end
            end
        end
        prev_valid = key_valid;
    end

    logic [15:0] cur;
    int          t;
    int          a;
    int          b;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_key_valid", key_valid, 0);
        chk("reset_key_held", key_held, 0);
        chk("reset_key_code", key_code, 0);
        rst = 1'b0;

        // Column strobe walks once per SCAN_DIV cycles.
        for (int k = 0; k < 5; k++) begin
            chk("col_step", col_out, 4'(~(4'b0001 << (k % 4))));
            if (k < 4) begin
                repeat (SCAN_DIV) @(posedge clk);
                #1;
            end
        end
        model_frame('0);

        // r2c1 held, then released.
        run_frames(16'h0040, 5);
        chk("r2c1_code", key_code, 4'h9);
        run_frames('0, 3);
        chk("r2c1_released", key_held, 0);

        // r0c3 bounces, then settles.
        for (int i = 0; i < 3; i++) begin
            run_frame(16'h1000);
            run_frame('0);
        end
        run_frames(16'h1000, 3);
        chk("r0c3_code", key_code, 4'h3);
        run_frames('0, 3);

        // r1c0 + r1c2 together, then r1c2 released.
        run_frames(16'h0202, 4);
        run_frames(16'h0002, 3);
        chk("r1c0_code", key_code, 4'h4);
        run_frames('0, 3);

        // Reset during debounce and during a held key.
        run_frames(16'h0040, 2);
        mid_reset(7);
        run_frames(16'h0040, 4);
        mid_reset(5);
        run_frames(16'h0040, 4);
        chk("rereg_held", key_held, 1);
        run_frames('0, 3);

        // r3c3 held long enough for auto-repeat when enabled.
        run_frames(16'h8000, 15);
        chk("r3c3_code", key_code, 4'hF);
        run_frames('0, 3);

        // Random frames with persistence so presses get accepted.
        cur = '0;
        for (int f = 0; f < 150; f++) begin
            t = $urandom_range(0, 9);
            if (t < 5) begin
                cur = cur;
            end else if (t < 7) begin
                cur = '0;
            end else if (t < 9) begin
                cur = '0;
                cur[$urandom_range(0, 15)] = 1'b1;
            end else begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                cur = '0;
                cur[a] = 1'b1;
                cur[b] = 1'b1;
            end
            run_frame(cur);
        end

        pressed = '0;
        repeat (20) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
